// File: rtl/vector_data_memory.sv
// Vector data memory: a core request port covering a memory-mapped IO region and a lane-packed
// main RAM, an element-granular readout port, and a word-per-cycle hardware clear engine.
module vector_data_memory #(
  parameter int unsigned LANES      = 6,
  parameter int unsigned ELEM_W     = 12,
  parameter int unsigned WORD_W     = 24,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned IO_WORDS   = 76,
  parameter int unsigned MAIN_DEPTH = 1024,
  parameter int unsigned SW_W       = 5,
  parameter int unsigned GPIO_W     = 36,
  parameter int unsigned B_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [LANES-1:0]        req_lane_mask,
  input  logic [LANES*WORD_W-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [LANES*WORD_W-1:0] rsp_rdata,
  output logic                    rsp_err,
  input  logic [ADDR_W-1:0]       b_addr,
  output logic [B_W-1:0]          b_data,
  input  logic [SW_W-1:0]         switches,
  input  logic [GPIO_W-1:0]       gpio_in,
  output logic [GPIO_W-1:0]       gpio_out,
  input  logic                    clr_start,
  output logic                    clr_busy,
  output logic                    clr_done
);

  localparam int unsigned IdxW = (MAIN_DEPTH > 1) ? $clog2(MAIN_DEPTH) : 1;
  localparam int unsigned ScrN = IO_WORDS - 5;
  localparam int unsigned GhiW = GPIO_W - WORD_W;
  localparam int unsigned BusW = LANES * WORD_W;
  localparam int unsigned RowW = LANES * ELEM_W;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    clr_idx_q, clr_idx_d;
  logic               clr_done_q, clr_done_d;
  logic [SW_W-1:0]    sw_s1_q, sw_s2_q;
  logic [GPIO_W-1:0]  gpio_out_q, gpio_out_d;
  logic [WORD_W-1:0]  scratch_q [ScrN];
  logic [WORD_W-1:0]  scratch_d [ScrN];
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [BusW-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [B_W-1:0]     b_data_q, b_data_d;

  logic [RowW-1:0]    ram [MAIN_DEPTH];

  logic               accept, is_io, is_main, main_we, io_we, clr_we;
  logic [IdxW-1:0]    main_idx;
  logic [RowW-1:0]    ram_rrow, ram_wrow, b_row;
  logic [BusW-1:0]    main_rdata;
  logic [WORD_W-1:0]  io_val, wd0;
  logic [ADDR_W-1:0]  b_word, b_lane;
  logic [ELEM_W-1:0]  b_elem;
  logic               unused_wdata;

  assign accept   = req_valid && (state_q == StIdle);
  assign is_io    = req_addr < ADDR_W'(IO_WORDS);
  assign is_main  = !is_io && (req_addr < ADDR_W'(IO_WORDS + MAIN_DEPTH));
  assign main_idx = IdxW'(req_addr - ADDR_W'(IO_WORDS));
  assign wd0      = req_wdata[WORD_W-1:0];
  // Writes are held off while reset is asserted so a mid-clear reset leaves RAM untouched.
  assign main_we  = rst && accept && req_write && is_main && (|req_lane_mask);
  assign io_we    = accept && req_write && is_io && req_lane_mask[0];
  assign clr_we   = rst && (state_q == StClear);
  // Lane bits above ELEM_W are not stored in main RAM.
  assign unused_wdata = ^req_wdata;

  // Main RAM row read, lane-merged write row and sign-extended read data.
  always_comb begin
    ram_rrow   = ram[main_idx];
    ram_wrow   = ram_rrow;
    main_rdata = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (req_lane_mask[i]) ram_wrow[i*ELEM_W +: ELEM_W] = req_wdata[i*WORD_W +: ELEM_W];
      main_rdata[i*WORD_W +: WORD_W] = WORD_W'($signed(ram_rrow[i*ELEM_W +: ELEM_W]));
    end
  end

  // IO region read mux.
  always_comb begin
    io_val = '0;
    if (req_addr == ADDR_W'(0))      io_val = WORD_W'(sw_s2_q);
    else if (req_addr == ADDR_W'(1)) io_val = gpio_in[WORD_W-1:0];
    else if (req_addr == ADDR_W'(2)) io_val = WORD_W'(gpio_in[GPIO_W-1:WORD_W]);
    else if (req_addr == ADDR_W'(3)) io_val = gpio_out_q[WORD_W-1:0];
    else if (req_addr == ADDR_W'(4)) io_val = WORD_W'(gpio_out_q[GPIO_W-1:WORD_W]);
    for (int unsigned s = 0; s < ScrN; s++) begin
      if (req_addr == ADDR_W'(s + 5)) io_val = scratch_q[s];
    end
  end

  // IO register writes and the core response.
  always_comb begin
    gpio_out_d = gpio_out_q;
    scratch_d  = scratch_q;
    if (io_we) begin
      if (req_addr == ADDR_W'(3)) gpio_out_d[WORD_W-1:0] = wd0;
      if (req_addr == ADDR_W'(4)) gpio_out_d[GPIO_W-1:WORD_W] = wd0[GhiW-1:0];
      for (int unsigned s = 0; s < ScrN; s++) begin
        if (req_addr == ADDR_W'(s + 5)) scratch_d[s] = wd0;
      end
    end
    rsp_valid_d = accept;
    rsp_err_d   = accept && !is_io && !is_main;
    rsp_rdata_d = '0;
    if (accept && !req_write) begin
      // IO reads replicate lane 0's top bit across the whole bus.
      if (is_io)        rsp_rdata_d = BusW'($signed(io_val));
      else if (is_main) rsp_rdata_d = main_rdata;
    end
  end

  // Port B element select; words beyond the RAM read as zero.
  always_comb begin
    b_word = b_addr / ADDR_W'(LANES);
    b_lane = b_addr % ADDR_W'(LANES);
    b_row  = ram[IdxW'(b_word)];
    b_elem = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (b_lane == ADDR_W'(l)) b_elem = b_row[l*ELEM_W +: ELEM_W];
    end
    b_data_d = (b_word < ADDR_W'(MAIN_DEPTH)) ? B_W'($signed(b_elem)) : '0;
  end

  // Clear engine next state: one word per cycle, done pulse after the last word.
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    clr_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_start) begin
          state_d   = StClear;
          clr_idx_d = '0;
        end
      end
      StClear: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == IdxW'(MAIN_DEPTH - 1)) begin
          state_d    = StIdle;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Main RAM storage; no reset. Requests stall during a clear so the two never collide.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      ram[clr_idx_q] <= '0;
    end else if (main_we) begin
      ram[main_idx] <= ram_wrow;
    end
  end

  // Registered state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      clr_idx_q   <= '0;
      clr_done_q  <= 1'b0;
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      gpio_out_q  <= '0;
      scratch_q   <= '{default: '0};
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      b_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      clr_done_q  <= clr_done_d;
      sw_s1_q     <= switches;
      sw_s2_q     <= sw_s1_q;
      gpio_out_q  <= gpio_out_d;
      scratch_q   <= scratch_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      b_data_q    <= b_data_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign clr_busy  = (state_q == StClear);
  assign clr_done  = clr_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign b_data    = b_data_q;
  assign gpio_out  = gpio_out_q;

endmodule

// File: tb/tb_vector_data_memory.sv
// Directed bench for vector_data_memory with default parameters.
module tb_vector_data_memory;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_write;
  logic [19:0]  req_addr;
  logic [5:0]   req_lane_mask;
  logic [143:0] req_wdata, rsp_rdata;
  logic         rsp_valid, rsp_err;
  logic [19:0]  b_addr;
  logic [15:0]  b_data;
  logic [4:0]   switches;
  logic [35:0]  gpio_in, gpio_out;
  logic         clr_start, clr_busy, clr_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vector_data_memory dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_lane_mask(req_lane_mask),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .switches     (switches),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out),
    .clr_start    (clr_start),
    .clr_busy     (clr_busy),
    .clr_done     (clr_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] lanes_all(input logic [23:0] v);
    return {6{v}};
  endfunction

  task automatic do_write(input logic [19:0] a, input logic [5:0] m, input logic [143:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_lane_mask = m; req_wdata = d;
    tick();
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic do_read(input logic [19:0] a);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic fill_ram();
    for (int w = 0; w < 1024; w++) begin
      do_write(20'(76 + w), 6'h3F, lanes_all(24'h000400 + 24'(w)));
    end
  endtask

  initial begin
    logic [143:0] d, e;
    int n;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_lane_mask = '0;
    req_wdata = '0; b_addr = '0; switches = '0; gpio_in = 36'h987654321; clr_start = 1'b0;
    tick(); tick();
    check("rst_ready", 144'(req_ready), 144'(1'b1));
    check("rst_rsp_valid", 144'(rsp_valid), 144'(1'b0));
    check("rst_rsp_rdata", rsp_rdata, 144'h0);
    check("rst_rsp_err", 144'(rsp_err), 144'(1'b0));
    check("rst_b_data", 144'(b_data), 144'h0);
    check("rst_gpio_out", 144'(gpio_out), 144'h0);
    check("rst_clr_busy", 144'(clr_busy), 144'(1'b0));
    check("rst_clr_done", 144'(clr_done), 144'(1'b0));
    rst = 1'b1;
    tick();

    // Negative elements sign-extend on read and on port B.
    for (int i = 0; i < 6; i++) begin
      d[i*24 +: 24] = 24'h000800 + 24'(i);
      e[i*24 +: 24] = 24'hFFF800 + 24'(i);
    end
    do_write(20'd76, 6'h3F, d);
    check("wr_rsp_valid", 144'(rsp_valid), 144'(1'b1));
    check("wr_rsp_rdata", rsp_rdata, 144'h0);
    check("wr_rsp_err", 144'(rsp_err), 144'(1'b0));
    do_read(20'd76);
    check("rd76", rsp_rdata, e);
    b_addr = 20'd3;
    tick();
    check("rsp_idle", 144'(rsp_valid), 144'(1'b0));
    check("b_addr3", 144'(b_data), 144'h0F803);

    // Lane mask, with read on the very next cycle.
    do_write(20'd77, 6'h3F, lanes_all(24'h000001));
    d = lanes_all(24'h000ABC);
    d[47:24] = 24'h0007FF;
    do_write(20'd77, 6'b000010, d);
    do_read(20'd77);
    e = lanes_all(24'h000001);
    e[47:24] = 24'h0007FF;
    check("mask77", rsp_rdata, e);
    b_addr = 20'd7;
    tick();
    check("b_addr7", 144'(b_data), 144'h07FF);
    b_addr = 20'd6144;
    tick();
    check("b_out_of_range", 144'(b_data), 144'h0);

    // GPIO outputs, gpio inputs and scratch.
    do_write(20'd3, 6'b000001, 144'h800001);
    do_write(20'd4, 6'b000001, 144'h00000A);
    check("gpio_out", 144'(gpio_out), 144'hA800001);
    do_read(20'd3);
    check("rd3", rsp_rdata, {{120{1'b1}}, 24'h800001});
    do_read(20'd4);
    check("rd4", rsp_rdata, 144'h00000A);
    do_write(20'd3, 6'b111110, 144'h0);
    check("gpio_no_lane0", 144'(gpio_out), 144'hA800001);
    do_read(20'd1);
    check("gpio_in_lo", rsp_rdata, 144'h654321);
    do_read(20'd2);
    check("gpio_in_hi", rsp_rdata, 144'h000987);
    do_read(20'd5);
    check("scratch5_rst", rsp_rdata, 144'h0);
    do_write(20'd75, 6'b000001, 144'hC00000);
    do_read(20'd75);
    check("scratch75", rsp_rdata, {{120{1'b1}}, 24'hC00000});

    // Switch synchroniser: two-edge delay, read-only.
    switches = 5'b10101;
    tick(); tick();
    do_read(20'd0);
    check("sw_rd", rsp_rdata, 144'h15);
    do_write(20'd0, 6'b000001, 144'hFFFFFF);
    do_read(20'd0);
    check("sw_ro", rsp_rdata, 144'h15);
    switches = 5'b01010;
    do_read(20'd0);
    check("sw_lag1", rsp_rdata, 144'h15);
    do_read(20'd0);
    check("sw_lag2", rsp_rdata, 144'h15);
    do_read(20'd0);
    check("sw_new", rsp_rdata, 144'h0A);

    // Out-of-range accesses and the last valid main word.
    do_read(20'd1100);
    check("err_rd_flag", 144'(rsp_err), 144'(1'b1));
    check("err_rd_data", rsp_rdata, 144'h0);
    do_write(20'd1100, 6'h3F, lanes_all(24'h000555));
    check("err_wr_flag", 144'(rsp_err), 144'(1'b1));
    for (int i = 0; i < 6; i++) e[i*24 +: 24] = 24'hFFF800 + 24'(i);
    do_read(20'd76);
    check("err_wr_dropped", rsp_rdata, e);
    do_write(20'd1099, 6'h3F, lanes_all(24'h000123));
    do_read(20'd1099);
    check("last_word", rsp_rdata, lanes_all(24'h000123));
    check("last_word_err", 144'(rsp_err), 144'(1'b0));

    // Full clear, started alongside a read request.
    fill_ram();
    clr_start = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 20'd77;
    tick();
    clr_start = 1'b0; req_valid = 1'b0;
    check("clr_same_cycle_rsp", 144'(rsp_valid), 144'(1'b1));
    check("clr_same_cycle_data", rsp_rdata, lanes_all(24'h000401));
    check("clr_busy", 144'(clr_busy), 144'(1'b1));
    check("clr_not_ready", 144'(req_ready), 144'(1'b0));
    n = 0;
    while (clr_busy === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    check("clr_cycles", 144'(n), 144'(1024));
    check("clr_done_pulse", 144'(clr_done), 144'(1'b1));
    check("clr_ready_back", 144'(req_ready), 144'(1'b1));
    tick();
    check("clr_done_low", 144'(clr_done), 144'(1'b0));
    for (int w = 0; w < 1024; w += 93) begin
      do_read(20'(76 + w));
      check("clr_word", rsp_rdata, 144'h0);
    end
    do_read(20'd1099);
    check("clr_word_last", rsp_rdata, 144'h0);

    // Clear interrupted by reset after 100 words.
    fill_ram();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (100) tick();
    rst = 1'b0;
    tick();
    check("mid_rst_busy", 144'(clr_busy), 144'(1'b0));
    check("mid_rst_ready", 144'(req_ready), 144'(1'b1));
    check("mid_rst_done", 144'(clr_done), 144'(1'b0));
    check("mid_rst_gpio", 144'(gpio_out), 144'h0);
    rst = 1'b1;
    tick();
    check("mid_rst_done_after", 144'(clr_done), 144'(1'b0));
    do_read(20'd76);
    check("part_w0", rsp_rdata, 144'h0);
    do_read(20'd126);
    check("part_w50", rsp_rdata, 144'h0);
    do_read(20'd175);
    check("part_w99", rsp_rdata, 144'h0);
    do_read(20'd176);
    check("part_w100", rsp_rdata, lanes_all(24'h000400 + 24'd100));
    do_read(20'd177);
    check("part_w101", rsp_rdata, lanes_all(24'h000400 + 24'd101));
    do_read(20'd1099);
    check("part_w1023", rsp_rdata, lanes_all(24'h000400 + 24'd1023));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
